// File: rtl/pwconv_feeder_pkg.sv
// pwconv_feeder_pkg
// Shared definitions for the PWConv feeder slice: FSM state encoding,
// default geometry of the third DSCNN layer, and derived bus widths.
package pwconv_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_BIAS_W      = 16;
  localparam int DEF_IN_CH       = 32;
  localparam int DEF_INPUT_NUM   = 36;
  localparam int DEF_OUT_CH      = 32;
  localparam int DEF_SLOT_CYCLES = 18;
  localparam int DEF_AW          = 5;

  // Filter-memory word: IN_CH weights in the low bits, bias on top.
  localparam int WMEM_W = DEF_IN_CH * DEF_DATA_W + DEF_BIAS_W;
  // Full DWConv output bundle.
  localparam int PIX_W  = DEF_IN_CH * DEF_INPUT_NUM * DEF_DATA_W;

endpackage

// File: rtl/pwconv_slot_timer.sv
// pwconv_slot_timer
// Slot counter and filter index for the PWConv feeder.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          restart at slot 0 / filter 0 (held in LOAD)
//   i_run            count while the FSM is in RUN
//   o_slot           registered pulse on the first cycle of every slot
//   o_pref_early     one cycle before the prefetch cycle (lets the read
//                    strobe be registered and still land on SLOT_CYCLES-2)
//   o_load           last cycle of a non-final slot: capture next filter
//   o_last           last cycle of the final slot
//   o_idx            filter currently presented
module pwconv_slot_timer #(
  parameter int SLOT_CYCLES = 18,
  parameter int OUT_CH      = 32,
  parameter int AW          = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_run,
  output logic          o_slot,
  output logic          o_pref_early,
  output logic          o_load,
  output logic          o_last,
  output logic [AW-1:0] o_idx
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_PREF = CW'(SLOT_CYCLES - 3);
  localparam logic [AW-1:0] IDX_LAST = AW'(OUT_CH - 1);

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_slot;
  logic          w_end;
  logic          w_more;

  assign w_end        = i_run && (r_cnt == CNT_LAST);
  // The index never passes IDX_LAST, so "not last" means "more to go".
  assign w_more       = (r_idx != IDX_LAST);
  assign o_load       = w_end && w_more;
  assign o_last       = w_end && !w_more;
  assign o_pref_early = i_run && (r_cnt == CNT_PREF) && w_more;
  assign o_slot       = r_slot;
  assign o_idx        = r_idx;

  // Slot counter and filter index; the index holds on the final slot so
  // the last filter stays visible after the pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (i_run) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        if (w_more) begin
          r_idx <= r_idx + AW'(1);
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Slot pulse lands on the cycle after LOAD or after a filter capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= 1'b0;
    end else begin
      r_slot <= i_clear || o_load;
    end
  end

endmodule

// File: rtl/pwconv_feeder.sv
// pwconv_feeder
// Transmit side of the PWConv stage: latches one DWConv bundle, then walks
// OUT_CH filters, presenting each filter's weights and bias for SLOT_CYCLES.
// Optional build macro PWCONV_FEEDER_OVERRUN_EN adds a sticky overrun_o flag
// for start_i arriving while busy.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start_i, pixel_i    pass request and the bundle valid with it
//   wmem_rd_o/addr_o    filter-memory read (data one cycle later)
//   wmem_data_i         {bias, weights[IN_CH-1:0]}
//   pwconv_*_o          bundle, current weights, current bias, pass pulse
//   slot_o, filter_idx_o  slot start pulse and current filter
//   busy_o, done_o      FSM not idle; pulse after the final slot
//   overrun_o           (macro only) sticky start-while-busy flag
module pwconv_feeder
  import pwconv_feeder_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BIAS_W      = DEF_BIAS_W,
  parameter int IN_CH       = DEF_IN_CH,
  parameter int INPUT_NUM   = DEF_INPUT_NUM,
  parameter int OUT_CH      = DEF_OUT_CH,
  parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int AW          = DEF_AW
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [IN_CH*INPUT_NUM*DATA_W-1:0] pixel_i,
  output logic                              wmem_rd_o,
  output logic [AW-1:0]                     wmem_addr_o,
  input  logic [IN_CH*DATA_W+BIAS_W-1:0]    wmem_data_i,
  output logic                              pwconv_valid_o,
  output logic [IN_CH*INPUT_NUM*DATA_W-1:0] pwconv_pixel_o,
  output logic [IN_CH*DATA_W-1:0]           pwconv_weight_o,
  output logic [BIAS_W-1:0]                 pwconv_bias_o,
  output logic                              slot_o,
  output logic [AW-1:0]                     filter_idx_o,
  output logic                              busy_o,
  output logic                              done_o
`ifdef PWCONV_FEEDER_OVERRUN_EN
  ,
  output logic                              overrun_o
`endif
);

  localparam int WEIGHT_W = IN_CH * DATA_W;
  localparam int MEM_W    = WEIGHT_W + BIAS_W;

  state_t                                r_state;
  state_t                                w_state_nxt;
  logic                                  w_accept;
  logic                                  w_pref_early;
  logic                                  w_load;
  logic                                  w_last;
  logic [AW-1:0]                         w_idx;
  logic                                  r_rd;
  logic [AW-1:0]                         r_addr;
  logic                                  r_valid;
  logic                                  r_done;
  logic                                  r_busy;
  logic [IN_CH*INPUT_NUM*DATA_W-1:0]     r_pixel;
  logic [WEIGHT_W-1:0]                   r_weight;
  logic [BIAS_W-1:0]                     r_bias;

  assign w_accept = (r_state == ST_IDLE) && start_i;

  pwconv_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .OUT_CH      (OUT_CH),
    .AW          (AW)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (r_state == ST_LOAD),
    .i_run        (r_state == ST_RUN),
    .o_slot       (slot_o),
    .o_pref_early (w_pref_early),
    .o_load       (w_load),
    .o_last       (w_last),
    .o_idx        (w_idx)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_nxt = ST_FETCH;
        else         w_state_nxt = ST_IDLE;
      end
      ST_FETCH: w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_RUN;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered strobes: each is decoded one cycle early so it appears on
  // the cycle it describes (read in FETCH / at SLOT_CYCLES-2, valid on the
  // first RUN cycle, done after the final slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rd    <= w_accept || w_pref_early;
      if (w_accept)          r_addr <= '0;
      else if (w_pref_early) r_addr <= w_idx + AW'(1);
      r_valid <= (r_state == ST_LOAD);
      r_done  <= w_last;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Datapath registers: bundle on an accepted start, filter word on LOAD
  // and at the end of every non-final slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel  <= '0;
      r_weight <= '0;
      r_bias   <= '0;
    end else begin
      if (w_accept) r_pixel <= pixel_i;
      if ((r_state == ST_LOAD) || w_load) begin
        r_weight <= wmem_data_i[WEIGHT_W-1:0];
        r_bias   <= wmem_data_i[MEM_W-1 -: BIAS_W];
      end
    end
  end

`ifdef PWCONV_FEEDER_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun; an accepted start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_overrun <= 1'b0;
    else if (w_accept)          r_overrun <= 1'b0;
    else if (start_i && r_busy) r_overrun <= 1'b1;
  end

  assign overrun_o = r_overrun;
`endif

  assign wmem_rd_o       = r_rd;
  assign wmem_addr_o     = r_addr;
  assign pwconv_valid_o  = r_valid;
  assign pwconv_pixel_o  = r_pixel;
  assign pwconv_weight_o = r_weight;
  assign pwconv_bias_o   = r_bias;
  assign filter_idx_o    = w_idx;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

endmodule

// File: tb/tb_pwconv_feeder.sv
// tb_pwconv_feeder
// Scoreboarded bench for pwconv_feeder. A default-geometry instance runs a
// fixed scenario (basic pass, start while busy, back-to-back, reset mid-pass)
// plus randomized passes; a second instance with SLOT_CYCLES=3, OUT_CH=4
// covers the minimum slot length. Optional macro PWCONV_FEEDER_OVERRUN_EN.
module tb_pwconv_feeder;

  localparam int DATA_W    = 8;
  localparam int BIAS_W    = 16;
  localparam int IN_CH     = 32;
  localparam int INPUT_NUM = 36;
  localparam int OUT_CH    = 32;
  localparam int SLOT      = 18;
  localparam int AW        = 5;
  localparam int WW        = IN_CH * DATA_W;
  localparam int PW        = IN_CH * INPUT_NUM * DATA_W;
  localparam int PASS_LEN  = 3 + OUT_CH * SLOT;

  typedef struct {
    int                cyc;
    int                k;
    logic [WW-1:0]     w;
    logic [BIAS_W-1:0] b;
  } ev_t;

  typedef struct {
    int            cyc;
    logic [PW-1:0] p;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   rst_n;
  logic                   start_i;
  logic [PW-1:0]          pixel_i;
  logic                   wmem_rd_o;
  logic [AW-1:0]          wmem_addr_o;
  logic [WW+BIAS_W-1:0]   wmem_data_i = '0;
  logic                   pwconv_valid_o;
  logic [PW-1:0]          pwconv_pixel_o;
  logic [WW-1:0]          pwconv_weight_o;
  logic [BIAS_W-1:0]      pwconv_bias_o;
  logic                   slot_o;
  logic [AW-1:0]          filter_idx_o;
  logic                   busy_o;
  logic                   done_o;
`ifdef PWCONV_FEEDER_OVERRUN_EN
  logic                   overrun_o;
`endif

  pwconv_feeder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .pixel_i         (pixel_i),
    .wmem_rd_o       (wmem_rd_o),
    .wmem_addr_o     (wmem_addr_o),
    .wmem_data_i     (wmem_data_i),
    .pwconv_valid_o  (pwconv_valid_o),
    .pwconv_pixel_o  (pwconv_pixel_o),
    .pwconv_weight_o (pwconv_weight_o),
    .pwconv_bias_o   (pwconv_bias_o),
    .slot_o          (slot_o),
    .filter_idx_o    (filter_idx_o),
    .busy_o          (busy_o),
    .done_o          (done_o)
`ifdef PWCONV_FEEDER_OVERRUN_EN
    ,
    .overrun_o       (overrun_o)
`endif
  );

  // Minimum-slot instance: 2 channels x 1 pixel, 4 filters, 3-cycle slots.
  logic        s2_start;
  logic [15:0] s2_pixel;
  logic        s2_rd;
  logic [1:0]  s2_addr;
  logic [31:0] s2_wdata = '0;
  logic        s2_valid;
  logic [15:0] s2_pixel_o;
  logic [15:0] s2_weight;
  logic [15:0] s2_bias;
  logic        s2_slot;
  logic [1:0]  s2_idx;
  logic        s2_busy;
  logic        s2_done;
`ifdef PWCONV_FEEDER_OVERRUN_EN
  logic        s2_overrun;
`endif

  pwconv_feeder #(
    .DATA_W(8), .BIAS_W(16), .IN_CH(2), .INPUT_NUM(1),
    .OUT_CH(4), .SLOT_CYCLES(3), .AW(2)
  ) dut_min (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (s2_start),
    .pixel_i         (s2_pixel),
    .wmem_rd_o       (s2_rd),
    .wmem_addr_o     (s2_addr),
    .wmem_data_i     (s2_wdata),
    .pwconv_valid_o  (s2_valid),
    .pwconv_pixel_o  (s2_pixel_o),
    .pwconv_weight_o (s2_weight),
    .pwconv_bias_o   (s2_bias),
    .slot_o          (s2_slot),
    .filter_idx_o    (s2_idx),
    .busy_o          (s2_busy),
    .done_o          (s2_done)
`ifdef PWCONV_FEEDER_OVERRUN_EN
    ,
    .overrun_o       (s2_overrun)
`endif
  );

  // Filter memories (one-cycle read latency).
  logic [WW-1:0]     mem_w [OUT_CH];
  logic [BIAS_W-1:0] mem_b [OUT_CH];
  always @(posedge clk) if (wmem_rd_o) wmem_data_i <= {mem_b[wmem_addr_o], mem_w[wmem_addr_o]};
  always @(posedge clk) if (s2_rd) s2_wdata <= {16'd50 + {14'd0, s2_addr}, 6'd0, s2_addr, 6'd0, s2_addr};

  // Scoreboard state.
  int   n_pass = 0;
  int   n_tot  = 0;
  int   q_valid[$];
  int   q_done[$];
  ev_t  q_rd[$];
  ev_t  q_slot[$];
  ev_t  q_ovr[$];
  pix_t q_pix[$];
  ev_t  q2_slot[$];
  int   q2_done[$];
  int   pass_start = -10;
  int   pass_done  = -1;
  logic [WW-1:0]     cur_w   = '0;
  logic [BIAS_W-1:0] cur_b   = '0;
  int                cur_idx = 0;
  logic [PW-1:0]     cur_pix = '0;
  logic              cur_ovr = 1'b0;
  logic              e_m;
  logic              e_m2;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  task automatic chk_pix(input logic [PW-1:0] exp);
    n_tot++;
    if (pwconv_pixel_o === exp) n_pass++;
    else $display("FAIL pixel_hold at cycle %0d: bundle differs, low word got %0h, expected %0h",
                  cyc, pwconv_pixel_o[31:0], exp[31:0]);
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] r;
    for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle start and record what the reference model expects.
  task automatic issue_start(input logic [PW-1:0] p);
    ev_t  ev;
    pix_t px;
    int   t;
    t = cyc;
    start_i = 1'b1;
    pixel_i = p;
    ev.w = '0;
    ev.b = '0;
    if (t > pass_done) begin
      q_valid.push_back(t + 3);
      q_done.push_back(t + PASS_LEN);
      px.cyc = t + 1;
      px.p   = p;
      q_pix.push_back(px);
      for (int k = 0; k < OUT_CH; k++) begin
        ev.k   = k;
        ev.cyc = t + 1 + k * SLOT;
        ev.w   = '0;
        ev.b   = '0;
        q_rd.push_back(ev);
        ev.cyc = t + 3 + k * SLOT;
        ev.w   = mem_w[k];
        ev.b   = mem_b[k];
        q_slot.push_back(ev);
      end
      pass_start = t;
      pass_done  = t + PASS_LEN;
      ev.k = 0;
    end else begin
      ev.k = 1;
    end
    ev.cyc = t + 1;
    q_ovr.push_back(ev);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    pixel_i = rand_pix();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q_valid.delete(); q_done.delete(); q_rd.delete();
    q_slot.delete();  q_ovr.delete();  q_pix.delete();
    pass_start = -10;
    pass_done  = -1;
    cur_w = '0; cur_b = '0; cur_idx = 0; cur_pix = '0; cur_ovr = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  // Monitor for the default instance, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctrl", WW'({pwconv_valid_o, slot_o, done_o, busy_o, wmem_rd_o, wmem_addr_o, filter_idx_o}), WW'(0));
      chk("reset_weight", pwconv_weight_o, WW'(0));
      chk("reset_bias", WW'(pwconv_bias_o), WW'(0));
      chk_pix('0);
`ifdef PWCONV_FEEDER_OVERRUN_EN
      chk("reset_overrun", WW'(overrun_o), WW'(0));
`endif
    end else begin
      e_m = (q_valid.size() > 0) && (q_valid[0] == cyc);
      if (e_m) void'(q_valid.pop_front());
      if (e_m || pwconv_valid_o) chk("valid_pulse", WW'(pwconv_valid_o), WW'(e_m));

      e_m = (q_done.size() > 0) && (q_done[0] == cyc);
      if (e_m) void'(q_done.pop_front());
      if (e_m || done_o) chk("done_pulse", WW'(done_o), WW'(e_m));

      e_m = (q_rd.size() > 0) && (q_rd[0].cyc == cyc);
      if (e_m) begin
        chk("rd_strobe", WW'(wmem_rd_o), WW'(1));
        chk("rd_addr", WW'(wmem_addr_o), WW'(q_rd[0].k));
        void'(q_rd.pop_front());
      end else if (wmem_rd_o) begin
        chk("rd_strobe", WW'(wmem_rd_o), WW'(0));
      end

      e_m = (q_slot.size() > 0) && (q_slot[0].cyc == cyc);
      if (e_m) begin
        cur_w   = q_slot[0].w;
        cur_b   = q_slot[0].b;
        cur_idx = q_slot[0].k;
        void'(q_slot.pop_front());
      end
      if (e_m || slot_o) chk("slot_pulse", WW'(slot_o), WW'(e_m));

      if ((q_pix.size() > 0) && (q_pix[0].cyc == cyc)) begin
        cur_pix = q_pix[0].p;
        void'(q_pix.pop_front());
      end
      if ((q_ovr.size() > 0) && (q_ovr[0].cyc == cyc)) begin
        cur_ovr = (q_ovr[0].k != 0);
        void'(q_ovr.pop_front());
      end

      chk("weight", pwconv_weight_o, cur_w);
      chk("bias", WW'(pwconv_bias_o), WW'(cur_b));
      chk("filter_idx", WW'(filter_idx_o), WW'(cur_idx));
      chk_pix(cur_pix);
      chk("busy", WW'(busy_o), WW'((cyc > pass_start) && (cyc <= pass_done)));
`ifdef PWCONV_FEEDER_OVERRUN_EN
      chk("overrun", WW'(overrun_o), WW'(cur_ovr));
`endif
    end
  end

  // Monitor for the minimum-slot instance.
  always @(negedge clk) begin
    if (rst_n) begin
      e_m2 = (q2_slot.size() > 0) && (q2_slot[0].cyc == cyc);
      if (e_m2) begin
        chk("min_slot_pulse", WW'(s2_slot), WW'(1));
        chk("min_filter_idx", WW'(s2_idx), WW'(q2_slot[0].k));
        chk("min_weight", WW'(s2_weight), q2_slot[0].w);
        chk("min_bias", WW'(s2_bias), WW'(q2_slot[0].b));
        chk("min_valid", WW'(s2_valid), WW'(q2_slot[0].k == 0));
        void'(q2_slot.pop_front());
      end else if (s2_slot) begin
        chk("min_slot_pulse", WW'(s2_slot), WW'(0));
      end
      e_m2 = (q2_done.size() > 0) && (q2_done[0] == cyc);
      if (e_m2) void'(q2_done.pop_front());
      if (e_m2 || s2_done) chk("min_done", WW'(s2_done), WW'(e_m2));
    end
  end

  // Minimum-slot stimulus: one pass starting at cycle 20.
  initial begin
    ev_t ev;
    s2_start = 1'b0;
    s2_pixel = 16'($urandom());
    go_to(20);
    s2_start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ev.cyc = cyc + 3 + 3 * k;
      ev.k   = k;
      ev.w   = WW'({8'(k), 8'(k)});
      ev.b   = 16'(50 + k);
      q2_slot.push_back(ev);
    end
    q2_done.push_back(cyc + 15);
    @(posedge clk);
    #1;
    s2_start = 1'b0;
  end

  // Main scenario.
  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    pixel_i = rand_pix();
    for (int k = 0; k < OUT_CH; k++) begin
      for (int i = 0; i < IN_CH; i++) mem_w[k][i*DATA_W +: DATA_W] = 8'(k);
      mem_b[k] = 16'(100 + k);
    end
    go_to(3);
    rst_n = 1'b1;

    go_to(10);
    issue_start(rand_pix());        // basic pass, done at 589
    go_to(200);
    issue_start(rand_pix());        // start while busy
    go_to(589);
    issue_start(rand_pix());        // in DONE: ignored
    issue_start(rand_pix());        // at 590: accepted

    go_to(900);
    do_reset();                     // abort the pass started at 590

    for (int k = 0; k < OUT_CH; k++) begin
      for (int i = 0; i < WW / 32; i++) mem_w[k][i*32 +: 32] = $urandom();
      mem_b[k] = 16'($urandom());
    end
    go_to(910);
    issue_start(rand_pix());        // valid at 913
    go_to(cyc + $urandom_range(20, 500));
    issue_start(rand_pix());        // random start while busy
    go_to(pass_done + 1 + $urandom_range(0, 5));
    issue_start(rand_pix());        // random gap after done
    go_to(pass_done + 10);

    chk("leftover_events", WW'(q_valid.size() + q_done.size() + q_rd.size() + q_slot.size()
                               + q_pix.size() + q_ovr.size() + q2_slot.size() + q2_done.size()),
        WW'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
